// File: rtl/keccak_squeeze.sv
// keccak_squeeze
// -----------------------------------------------------------------------------
// Squeeze-side reader for the SHAKE datapath. Captures the rate lanes of a
// permuted 1600-bit Keccak state and streams them out as 64-bit words over a
// valid/ready interface. When a block's rate lanes are used up and more words
// are still owed, it pulses perm_req and waits for the next permuted state.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   abort         (only with SQUEEZE_ABORT_EN) force IDLE on the next edge
//   start/out_len begin a request of out_len words (sampled only in IDLE)
//   busy          high whenever the FSM is not IDLE
//   state_valid/state_ready/state_in   permuted state input handshake
//                 (lane k = state_in[STATE_W-1-64k -: 64], lane 0 at the MSBs)
//   perm_req      one-cycle pulse asking for another permutation
//   dout/dout_valid/dout_ready/dout_last   output word stream
//   done          one-cycle pulse when the request completes
//
// Build option: define SQUEEZE_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module keccak_squeeze #(
   parameter int STATE_W    = 1600,
   parameter int W          = 64,
   parameter int RATE_LANES = 21,
   parameter int LEN_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
`ifdef SQUEEZE_ABORT_EN
   input  logic               abort,
`endif
   input  logic               start,
   input  logic [LEN_W-1:0]   out_len,
   output logic               busy,
   input  logic               state_valid,
   output logic               state_ready,
   input  logic [STATE_W-1:0] state_in,
   output logic               perm_req,
   output logic [W-1:0]       dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               dout_last,
   output logic               done
);

   localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
   localparam int NUM_LANES = STATE_W / W;

   typedef enum logic [1:0] {IDLE, WAIT_ST, DRAIN} fsm_t;

   fsm_t             state_reg, state_next;
   logic [LEN_W-1:0] remaining_reg, remaining_next;
   logic [CNT_W-1:0] lane_cnt_reg, lane_cnt_next;
   logic             state_ready_reg, state_ready_next;
   logic             perm_req_reg, perm_req_next;
   logic             dout_valid_reg, dout_valid_next;
   logic             done_reg, done_next;

   logic [W-1:0]     lane_buf [RATE_LANES];
   logic [W-1:0]     rate_lane [RATE_LANES];
   logic             abort_int;
   logic             state_hs;
   logic             word_hs;
   logic             load;

`ifdef SQUEEZE_ABORT_EN
   assign abort_int = abort;
`else
   assign abort_int = 1'b0;
`endif

   // Slice the rate lanes out of the state; lane 0 sits at the MSBs.
   generate
      for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
         assign rate_lane[gi] = state_in[STATE_W-1-W*gi -: W];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lane_buf[gi] <= '0;
            end else if (load) begin
               lane_buf[gi] <= rate_lane[gi];
            end
         end
      end

      // Capacity lanes are never stored or emitted.
      if (RATE_LANES < NUM_LANES) begin : g_cap
         logic unused_cap;
         assign unused_cap = ^state_in[STATE_W-1-W*RATE_LANES:0];
      end
   endgenerate

   assign state_hs = state_valid & state_ready_reg;
   assign word_hs  = dout_valid_reg & dout_ready;

   always_comb begin
      state_next       = state_reg;
      remaining_next   = remaining_reg;
      lane_cnt_next    = lane_cnt_reg;
      state_ready_next = state_ready_reg;
      dout_valid_next  = dout_valid_reg;
      perm_req_next    = 1'b0;
      done_next        = 1'b0;
      load             = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (out_len == '0) begin
                  done_next = 1'b1;
               end else begin
                  remaining_next   = out_len;
                  state_next       = WAIT_ST;
                  state_ready_next = 1'b1;
               end
            end
         end

         WAIT_ST: begin
            if (state_hs) begin
               load             = 1'b1;
               lane_cnt_next    = '0;
               state_ready_next = 1'b0;
               dout_valid_next  = 1'b1;
               state_next       = DRAIN;
            end
         end

         DRAIN: begin
            if (word_hs) begin
               remaining_next = remaining_reg - 1'b1;
               // Completion wins over the block boundary so no permutation is
               // requested after the final word.
               if (remaining_reg == LEN_W'(1)) begin
                  state_next      = IDLE;
                  dout_valid_next = 1'b0;
                  done_next       = 1'b1;
               end else if (lane_cnt_reg == CNT_W'(RATE_LANES - 1)) begin
                  state_next       = WAIT_ST;
                  dout_valid_next  = 1'b0;
                  perm_req_next    = 1'b1;
                  state_ready_next = 1'b1;
               end else begin
                  lane_cnt_next = lane_cnt_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort overrides any handshake seen in the same cycle.
      if (abort_int) begin
         state_next       = IDLE;
         state_ready_next = 1'b0;
         dout_valid_next  = 1'b0;
         perm_req_next    = 1'b0;
         done_next        = 1'b0;
         load             = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         remaining_reg   <= '0;
         lane_cnt_reg    <= '0;
         state_ready_reg <= 1'b0;
         perm_req_reg    <= 1'b0;
         dout_valid_reg  <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         remaining_reg   <= remaining_next;
         lane_cnt_reg    <= lane_cnt_next;
         state_ready_reg <= state_ready_next;
         perm_req_reg    <= perm_req_next;
         dout_valid_reg  <= dout_valid_next;
         done_reg        <= done_next;
      end
   end

   // dout is read straight from the buffer so it holds while stalled.
   assign dout        = dout_valid_reg ? lane_buf[lane_cnt_reg] : '0;
   assign dout_valid  = dout_valid_reg;
   assign dout_last   = dout_valid_reg & (remaining_reg == LEN_W'(1));
   assign state_ready = state_ready_reg;
   assign perm_req    = perm_req_reg;
   assign done        = done_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze
// Two DUT instances (RATE_LANES 21 and 17). A behavioural model builds the
// expected word stream as the concatenated rate lanes of successive blocks,
// truncated to out_len; a negedge compare process checks every cycle.
module tb_keccak_squeeze;
   localparam int STATE_W = 1600;
   localparam int W       = 64;
   localparam int LEN_W   = 32;
   localparam int NB      = 8;
   localparam int NW      = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic               start       [2];
   logic [LEN_W-1:0]   out_len     [2];
   logic               busy        [2];
   logic               state_valid [2];
   logic               state_ready [2];
   logic [STATE_W-1:0] state_in    [2];
   logic               perm_req    [2];
   logic [W-1:0]       dout        [2];
   logic               dout_valid  [2];
   logic               dout_ready  [2];
   logic               dout_last   [2];
   logic               done        [2];
`ifdef SQUEEZE_ABORT_EN
   logic               abort       [2];
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      keccak_squeeze #(.RATE_LANES(gi == 0 ? 21 : 17)) u_dut (
         .clk(clk),
         .rst(rst),
`ifdef SQUEEZE_ABORT_EN
         .abort(abort[gi]),
`endif
         .start(start[gi]),
         .out_len(out_len[gi]),
         .busy(busy[gi]),
         .state_valid(state_valid[gi]),
         .state_ready(state_ready[gi]),
         .state_in(state_in[gi]),
         .perm_req(perm_req[gi]),
         .dout(dout[gi]),
         .dout_valid(dout_valid[gi]),
         .dout_ready(dout_ready[gi]),
         .dout_last(dout_last[gi]),
         .done(done[gi])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;

   // model data (written by the driver)
   logic [63:0] blk     [2][NB][25];
   logic [63:0] exp_mem [2][NW];
   int          exp_len [2] = '{0, 0};
   int          run_id  [2] = '{0, 0};

   // monitor-owned tracking
   int          seen_id  [2] = '{0, 0};
   int          rd_idx   [2] = '{0, 0};
   int          perm_cnt [2] = '{0, 0};
   int          done_cnt [2] = '{0, 0};
   int          vcnt     [2] = '{0, 0};
   logic [63:0] vseq     [2][16];
   logic        prev_hs [2], prev_stall [2], prev_last_hs [2], prev_zero [2], prev_perm [2];
   logic [63:0] prev_dout [2];

   logic [63:0] lit_basic [3] = '{64'd1, 64'd2, 64'd3};
   logic [63:0] lit_bp    [7] = '{64'd1, 64'd2, 64'd2, 64'd2, 64'd3, 64'd3, 64'd4};
   bit          pat       [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   function automatic int rl(input int d);
      return (d == 0) ? 21 : 17;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // compare process
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (run_id[d] != seen_id[d]) begin
            seen_id[d]  = run_id[d];
            rd_idx[d]   = 0;
            perm_cnt[d] = 0;
            done_cnt[d] = 0;
            vcnt[d]     = 0;
         end
         if (rst) begin
            prev_hs[d] = 0; prev_stall[d] = 0; prev_last_hs[d] = 0;
            prev_zero[d] = 0; prev_perm[d] = 0; prev_dout[d] = '0;
         end else begin
            chk("done", done[d], prev_last_hs[d] | prev_zero[d]);
            chk("perm_req", perm_req[d], prev_perm[d]);
            if (prev_hs[d]) chk("first_valid_latency", dout_valid[d], 1);
            if (prev_stall[d]) begin
               chk("stall_valid", dout_valid[d], 1);
               chk("stall_data", dout[d], prev_dout[d]);
            end
            if (dout_valid[d] || state_ready[d] || perm_req[d]) chk("busy", busy[d], 1);
            if (dout_valid[d]) begin
               if (rd_idx[d] < exp_len[d]) begin
                  chk("dout", dout[d], exp_mem[d][rd_idx[d]]);
                  chk("dout_last", dout_last[d], rd_idx[d] == exp_len[d] - 1);
               end else begin
                  chk("extra_word", rd_idx[d] + 1, exp_len[d]);
               end
               if (vcnt[d] < 16) vseq[d][vcnt[d]] = dout[d];
               vcnt[d]++;
            end
            prev_hs[d]      = state_valid[d] & state_ready[d];
            prev_stall[d]   = dout_valid[d] & ~dout_ready[d];
            prev_dout[d]    = dout[d];
            prev_last_hs[d] = dout_valid[d] & dout_ready[d] & (rd_idx[d] == exp_len[d] - 1);
            prev_perm[d]    = dout_valid[d] & dout_ready[d] &
                              ((rd_idx[d] + 1) % rl(d) == 0) & (rd_idx[d] + 1 < exp_len[d]);
            prev_zero[d]    = start[d] & (out_len[d] == '0);
            if (perm_req[d]) perm_cnt[d]++;
            if (done[d]) done_cnt[d]++;
            if (dout_valid[d] & dout_ready[d]) rd_idx[d]++;
         end
      end
   end

   task automatic check_all_zero(input int d, input string tag);
      chk({tag, "_busy"}, busy[d], 0);
      chk({tag, "_state_ready"}, state_ready[d], 0);
      chk({tag, "_perm_req"}, perm_req[d], 0);
      chk({tag, "_dout"}, dout[d], 0);
      chk({tag, "_dout_valid"}, dout_valid[d], 0);
      chk({tag, "_dout_last"}, dout_last[d], 0);
      chk({tag, "_done"}, done[d], 0);
   endtask

   // kind: 0 pattern lanes, 1 random lanes
   // rmode: 0 ready always, 1 random ready, 2 fixed pattern
   // cut: 0 none, 1 reset after 2nd word, 2 abort after first perm_req
   task automatic run(input int d, input int len, input int kind, input int rmode, input int cut);
      int r = rl(d);
      int nb = 0;
      int wait_c;
      int pidx = 0;
      bit pend, fin, hs, pr, dn, stalled, aborted;
      fin = 0; stalled = 0; aborted = 0;
      for (int b = 0; b < NB; b++)
         for (int k = 0; k < 25; k++)
            blk[d][b][k] = (kind == 0) ? ((b == 0) ? 64'(k + 1) : 64'(256 * b + k))
                                       : {$urandom, $urandom};
      for (int i = 0; i < len && i < NW; i++) exp_mem[d][i] = blk[d][i / r][i % r];
      exp_len[d] = len;
      run_id[d]++;
      $display("run: inst=%0d R=%0d len=%0d kind=%0d rmode=%0d cut=%0d", d, r, len, kind, rmode, cut);
      out_len[d] = LEN_W'(len);
      start[d] = 1;
      @(posedge clk); #1;
      start[d] = 0;
      pend = (len > 0);
      wait_c = $urandom_range(0, 2);
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         dout_ready[d] = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1))
                                             : (pidx < 7 ? pat[pidx] : 1'b1);
         if (pend && wait_c == 0 && nb < NB) begin
            state_valid[d] = 1;
            for (int k = 0; k < 25; k++) state_in[d][STATE_W-1-64*k -: 64] = blk[d][nb][k];
         end else begin
            // while stalled the DUT is surely draining: junk must be ignored
            state_valid[d] = stalled;
            state_in[d] = {50{$urandom}};
         end
         @(negedge clk);
         hs = state_valid[d] & state_ready[d];
         pr = perm_req[d];
         dn = done[d];
         stalled = dout_valid[d] & ~dout_ready[d];
         if (rmode == 2 && dout_valid[d]) pidx++;
         @(posedge clk); #1;
         if (hs) begin pend = 0; nb++; end
         else if (pend && wait_c > 0) wait_c--;
         if (pr) begin pend = 1; wait_c = $urandom_range(0, 2); end
         if (dn) fin = 1;
         if (cut == 1 && rd_idx[d] == 2) begin
            rst = 1;
            #1;
            check_all_zero(d, "rst_mid");
            @(posedge clk); #1;
            rst = 0;
            fin = 1;
         end
`ifdef SQUEEZE_ABORT_EN
         if (cut == 2 && pr) begin
            abort[d] = 1;
            state_valid[d] = 0;
            @(posedge clk); #1;
            abort[d] = 0;
            chk("abort_state_ready", state_ready[d], 0);
            chk("abort_busy", busy[d], 0);
            chk("abort_dout_valid", dout_valid[d], 0);
            chk("abort_perm_req", perm_req[d], 0);
            state_valid[d] = 1;
            repeat (3) begin
               @(posedge clk); #1;
               chk("abort_ignore_ready", state_ready[d], 0);
               chk("abort_ignore_valid", dout_valid[d], 0);
               chk("abort_ignore_busy", busy[d], 0);
            end
            state_valid[d] = 0;
            aborted = 1;
            fin = 1;
         end
`endif
      end
      state_valid[d] = 0;
      dout_ready[d] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("run_finished", fin, 1);
      chk("busy_after", busy[d], 0);
      if (cut == 0) begin
         chk("word_count", rd_idx[d], len);
         chk("perm_count", perm_cnt[d], (len == 0) ? 0 : (len + r - 1) / r - 1);
         chk("done_count", done_cnt[d], 1);
      end else begin
         chk("no_done_after_cut", done_cnt[d], 0);
         if (cut == 2) chk("abort_taken", aborted, 1);
      end
   endtask

   initial begin
      rst = 1;
      for (int d = 0; d < 2; d++) begin
         start[d] = 0; out_len[d] = '0; state_valid[d] = 0;
         state_in[d] = '0; dout_ready[d] = 0;
`ifdef SQUEEZE_ABORT_EN
         abort[d] = 0;
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check_all_zero(d, "reset");
      rst = 0;
      @(posedge clk); #1;

      // stray state_valid in IDLE
      state_valid[0] = 1;
      state_in[0] = {50{$urandom}};
      repeat (2) @(posedge clk);
      #1;
      chk("idle_state_ready", state_ready[0], 0);
      chk("idle_busy", busy[0], 0);
      chk("idle_dout_valid", dout_valid[0], 0);
      state_valid[0] = 0;

      run(0, 3, 0, 0, 0);
      chk("basic_count", vcnt[0], 3);
      for (int i = 0; i < 3; i++) chk("basic_word", vseq[0][i], lit_basic[i]);

      run(0, 23, 0, 0, 0);
      chk("multi_model_w21", exp_mem[0][21], 64'h100);
      chk("multi_model_w22", exp_mem[0][22], 64'h101);
      chk("multi_perm", perm_cnt[0], 1);

      run(0, 21, 0, 0, 0);
      chk("exact21_perm", perm_cnt[0], 0);
      run(1, 17, 0, 0, 0);
      chk("exact17_perm", perm_cnt[1], 0);
      chk("exact17_model_last", exp_mem[1][16], 64'd17);

      run(0, 4, 0, 2, 0);
      chk("bp_valid_cycles", vcnt[0], 7);
      for (int i = 0; i < 7; i++) chk("bp_word", vseq[0][i], lit_bp[i]);

      run(0, 0, 0, 0, 0);
      chk("zero_no_words", vcnt[0], 0);

      run(0, 10, 0, 0, 1);

`ifdef SQUEEZE_ABORT_EN
      run(0, 30, 1, 0, 2);
`endif

      for (int t = 0; t < 12; t++)
         run(int'($urandom_range(0, 1)), int'($urandom_range(0, 100)), 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
Squeeze-side reader for the SHAKE datapath. It takes the 1600-bit state produced by the permutation (keccak_round iterations) and serialises the rate lanes as 64-bit words over a valid/ready stream. When a block's rate is exhausted and more output is owed, it requests a further permutation. It sits between the permutation core and the output FIFO/host interface, opposite the absorb path that writes the state.

Parameters:
STATE_W, 1600, state width (fixed 1600; 25 lanes of 64)
W, 64, lane width and output word width
RATE_LANES, 21, rate in lanes (21 = SHAKE128, 17 = SHAKE256); legal range 1..25
LEN_W, 32, width of the requested-length counter (in words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin squeezing; sampled only in IDLE
out_len  in  LEN_W  number of 64-bit words to output; sampled with start
busy  out  1  high in any state other than IDLE
state_valid  in  1  permutation core has a fresh state on state_in
state_ready  out  1  block accepts state_in this cycle
state_in  in  STATE_W  permuted state; lane k = state_in[STATE_W-1-64k -: 64] (lane 0 = Aba at the MSBs)
perm_req  out  1  one-cycle pulse: run another permutation on the held state
dout  out  W  output word
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  downstream accepts dout
dout_last  out  1  dout is the final word of the request
done  out  1  one-cycle pulse when the request completes

Behaviour:
- Reset (async, rst=1): FSM to IDLE. busy, state_ready, perm_req, dout_valid, dout_last and done are 0. dout is 0, the lane buffer is 0 and all counters are 0.
- States: IDLE, WAIT_ST, DRAIN.
- IDLE, start=1, out_len=0: stay in IDLE. done=1 on the next cycle. No output words and no perm_req.
- IDLE, start=1, out_len>0: latch remaining=out_len and go to WAIT_ST. start is ignored outside IDLE.
- WAIT_ST: state_ready=1 (registered, high from the first cycle in WAIT_ST). On state_valid & state_ready:
  - copy lanes 0..RATE_LANES-1 into the internal buffer;
  - set lane_cnt=0;
  - go to DRAIN next cycle.
  - Capacity lanes are never stored or emitted.
- DRAIN: dout_valid=1 and dout = buffer[lane_cnt]. dout_last=1 when remaining==1.
- Handshake (dout_valid & dout_ready): remaining--, lane_cnt++. Then, in priority order:
  (a) remaining was 1: go to IDLE; dout_valid=0 next cycle; done=1 for one cycle.
  (b) lane_cnt was RATE_LANES-1: go to WAIT_ST; perm_req=1 for exactly one cycle (the first WAIT_ST cycle).
  (c) otherwise: stay in DRAIN.
- Case (a) takes priority over (b) when both hold, so no perm_req is issued after the last word.
- Backpressure: while dout_valid=1 and dout_ready=0, dout and dout_last hold stable. Throughput is one word per cycle under continuous dout_ready.
- Latency: the first dout_valid occurs 1 cycle after the state handshake. Between blocks there is a gap of at least 2 cycles: the perm_req cycle, then state acceptance.
- state_valid in IDLE or DRAIN is ignored (state_ready=0).
- remaining is LEN_W wide. out_len = 2^LEN_W-1 is legal, and the block keeps requesting permutations until it is exhausted.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse. A partially drained block is discarded.

Optional Feature:
SQUEEZE_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in any state forces IDLE on the next edge, with dout_valid, state_ready and perm_req deasserted that cycle. done is not pulsed. abort has priority over every handshake in the same cycle, so a word presented that cycle does not count as transferred.
- Undefined: the port is absent and the FSM is unchanged.

Test Plan:
- Basic: state_in lane k = k+1. start, out_len=3, RATE_LANES=21, dout_ready=1 -> dout 1, 2, 3 on consecutive cycles; dout_last only on 3; done one cycle later; perm_req never high.
- Multi-block: out_len=23 -> words 1..21, then a single perm_req pulse. Supply a second state with lane k = 0x100+k -> words 0x100, 0x101; last on 0x101; done. Exactly one perm_req in total.
- Exact block boundary: out_len=21 -> 21 words, last on word 21, done, zero perm_req pulses. Repeat with RATE_LANES=17, out_len=17 -> same behaviour.
- Backpressure: out_len=4 with dout_ready pattern 1,0,0,1,0,1,1 -> dout sequence 1,2,2,2,3,3,4 with dout_valid=1 throughout; data stable while stalled; no word dropped or duplicated.
- Zero length / reset: start with out_len=0 -> done the next cycle and dout_valid stays 0. Start out_len=10 and assert rst after the 2nd word -> all outputs 0 in the same cycle; busy=0; no done pulse.
- Abort (SQUEEZE_ABORT_EN): out_len=30, abort during WAIT_ST after perm_req -> IDLE next cycle; state_ready=0; a subsequent state_valid is ignored; no done pulse.
